// File: rtl/timing_decode.sv
// Basic-computer timing and control front end: run/halt FSM, sequence counter, T/D decode, IR.
// Define SINGLE_STEP_EN to add the step input and the STEP state.
module timing_decode (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        halt_req,
   input  logic        clrsc,
   input  logic        ldir,
`ifdef SINGLE_STEP_EN
   input  logic        step,
`endif
   input  logic [7:0]  bus_in,
   output logic [7:0]  T,
   output logic [7:0]  D,
   output logic        I,
   output logic [7:0]  B,
   output logic [7:0]  ir,
   output logic [2:0]  sc,
   output logic        running,
   output logic [15:0] instr_count,
   output logic        sc_wrap_err
);

`ifdef SINGLE_STEP_EN
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT, S_STEP} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;
`endif

   state_t      r_state;
   logic [2:0]  r_sc;
   logic [7:0]  r_ir;
   logic [15:0] r_cnt;
   logic        r_err;
   logic        w_active;
   logic [7:0]  w_t;

`ifdef SINGLE_STEP_EN
   assign w_active = (r_state == S_RUN) || (r_state == S_STEP);
`else
   assign w_active = (r_state == S_RUN);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_sc    <= '0;
         r_ir    <= '0;
         r_cnt   <= '0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (start) r_state <= S_RUN;
            S_HALT: begin
               if (start) r_state <= S_RUN;
`ifdef SINGLE_STEP_EN
               else if (step) r_state <= S_STEP;
`endif
            end
            S_RUN:  if (clrsc && halt_req) r_state <= S_HALT;
`ifdef SINGLE_STEP_EN
            S_STEP: if (clrsc) r_state <= S_HALT;
`endif
            default: r_state <= S_IDLE;
         endcase

         // SC and IR only move while an instruction stream is active
         if (w_active) begin
            if (clrsc) begin
               r_sc  <= '0;
               r_cnt <= r_cnt + 16'd1;
            end else begin
               r_sc <= r_sc + 3'd1;
               if (r_sc == 3'd7) r_err <= 1'b1;
            end
            if (ldir) r_ir <= bus_in;
         end
      end
   end

   always_comb begin
      w_t = '0;
      if (w_active) w_t[r_sc] = 1'b1;
   end

   assign T           = w_t;
   assign D           = 8'h01 << r_ir[6:4];
   assign I           = r_ir[7];
   assign B           = {4'b0000, r_ir[3:0]};
   assign ir          = r_ir;
   assign sc          = r_sc;
   assign running     = w_active;
   assign instr_count = r_cnt;
   assign sc_wrap_err = r_err;

endmodule

// File: tb/tb_timing_decode.sv
// Self-checking bench for timing_decode; T/sc/running go through a cycle-tagged scoreboard.
`timescale 1ns/1ps
module tb_timing_decode;

   logic        clk = 1'b0;
   logic        rst, start, halt_req, clrsc, ldir, step;
   logic [7:0]  bus_in;
   logic [7:0]  T, D, B, ir;
   logic        I, running, sc_wrap_err;
   logic [2:0]  sc;
   logic [15:0] instr_count;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   typedef struct {
      logic [7:0] t;
      logic [2:0] s;
      logic       r;
      int         due;
   } exp_t;
   exp_t q[$];

   timing_decode dut (
      .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
      .clrsc(clrsc), .ldir(ldir),
`ifdef SINGLE_STEP_EN
      .step(step),
`endif
      .bus_in(bus_in), .T(T), .D(D), .I(I), .B(B), .ir(ir), .sc(sc),
      .running(running), .instr_count(instr_count), .sc_wrap_err(sc_wrap_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Scoreboard consumer: compare each entry once the cycle it targets has been clocked
   always @(negedge clk) begin
      while (q.size() > 0 && q[0].due <= cyc) begin
         exp_t e;
         e = q.pop_front();
         tests++;
         if (T !== e.t || sc !== e.s || running !== e.r) begin
            fails++;
            $display("FAIL sb cyc%0d: T=%h sc=%0d run=%b, want T=%h sc=%0d run=%b",
                     cyc, T, sc, running, e.t, e.s, e.r);
         end
      end
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic tick;
      @(posedge clk); #1;
   endtask

   task automatic cyc_exp(input logic [7:0] t, input logic [2:0] s, input logic r);
      exp_t e;
      e.t = t; e.s = s; e.r = r; e.due = cyc + 1;
      q.push_back(e);
      tick();
   endtask

   task automatic clear_inputs;
      start = 0; halt_req = 0; clrsc = 0; ldir = 0; step = 0; bus_in = 8'h00;
   endtask

   task automatic do_reset;
      clear_inputs();
      rst = 1;
      cyc_exp(8'h00, 3'd0, 1'b0);
      rst = 0;
   endtask

   task automatic test_reset;
      rst = 1; clear_inputs();
      tick();
      do_reset();
      tests++;
      if (D !== 8'h01 || I !== 1'b0 || B !== 8'h00 || ir !== 8'h00 ||
          instr_count !== 16'h0000 || sc_wrap_err !== 1'b0) begin
         fails++;
         $display("FAIL reset_state: D=%h I=%b B=%h ir=%h cnt=%h err=%b, want 01 0 00 00 0000 0",
                  D, I, B, ir, instr_count, sc_wrap_err);
      end
      cyc_exp(8'h00, 3'd0, 1'b0);   // idle holds, clrsc/ldir ignored
   endtask

   task automatic test_start;
      do_reset();
      start = 1; cyc_exp(8'h01, 3'd0, 1'b1);
      start = 0;
      cyc_exp(8'h02, 3'd1, 1'b1);
      cyc_exp(8'h04, 3'd2, 1'b1);
      cyc_exp(8'h08, 3'd3, 1'b1);
   endtask

   task automatic test_instr;
      do_reset();
      start = 1; cyc_exp(8'h01, 3'd0, 1'b1);
      start = 0; cyc_exp(8'h02, 3'd1, 1'b1);
      ldir = 1; bus_in = 8'hA5;
      cyc_exp(8'h04, 3'd2, 1'b1);
      ldir = 0; bus_in = 8'h00;
      tests++;
      if (ir !== 8'hA5 || I !== 1'b1 || D !== 8'h04 || B !== 8'h05) begin
         fails++;
         $display("FAIL ir_decode: ir=%h I=%b D=%h B=%h, want A5 1 04 05", ir, I, D, B);
      end
      cyc_exp(8'h08, 3'd3, 1'b1);
      clrsc = 1; cyc_exp(8'h01, 3'd0, 1'b1);
      clrsc = 0;
      tests++;
      if (instr_count !== 16'd1) begin
         fails++;
         $display("FAIL instr_count_1: got %0d want 1", instr_count);
      end
   endtask

   task automatic test_halt;
      halt_req = 1;
      cyc_exp(8'h02, 3'd1, 1'b1);
      cyc_exp(8'h04, 3'd2, 1'b1);
      cyc_exp(8'h08, 3'd3, 1'b1);
      cyc_exp(8'h10, 3'd4, 1'b1);
      clrsc = 1; cyc_exp(8'h00, 3'd0, 1'b0);
      clrsc = 0; halt_req = 0;
      ldir = 1; bus_in = 8'hFF; clrsc = 1;
      cyc_exp(8'h00, 3'd0, 1'b0);
      ldir = 0; clrsc = 0;
      tests++;
      if (ir !== 8'hA5 || instr_count !== 16'd2) begin
         fails++;
         $display("FAIL halt_hold: ir=%h cnt=%0d, want A5 2", ir, instr_count);
      end
      start = 1; cyc_exp(8'h01, 3'd0, 1'b1);
      start = 0;
   endtask

   task automatic test_wrap;
      for (int unsigned k = 1; k <= 7; k++) begin
         start = (k == 3);       // start while active has no effect
         cyc_exp(8'h01 << k, 3'(k), 1'b1);
      end
      start = 0;
      tests++;
      if (sc_wrap_err !== 1'b0) begin
         fails++;
         $display("FAIL wrap_early: err=%b want 0", sc_wrap_err);
      end
      cyc_exp(8'h01, 3'd0, 1'b1);
      tests++;
      if (sc_wrap_err !== 1'b1) begin
         fails++;
         $display("FAIL wrap_set: err=%b want 1", sc_wrap_err);
      end
      clrsc = 1; cyc_exp(8'h01, 3'd0, 1'b1);
      clrsc = 0; cyc_exp(8'h02, 3'd1, 1'b1);
      tests++;
      if (sc_wrap_err !== 1'b1) begin
         fails++;
         $display("FAIL wrap_sticky: err=%b want 1", sc_wrap_err);
      end
   endtask

   task automatic test_reset_mid;
      do_reset();
      start = 1; cyc_exp(8'h01, 3'd0, 1'b1);
      start = 0; ldir = 1; bus_in = 8'h3C;
      cyc_exp(8'h02, 3'd1, 1'b1);
      ldir = 0; bus_in = 8'h00;
      cyc_exp(8'h04, 3'd2, 1'b1);
      cyc_exp(8'h08, 3'd3, 1'b1);
      cyc_exp(8'h10, 3'd4, 1'b1);
      clrsc = 1; cyc_exp(8'h01, 3'd0, 1'b1);
      clrsc = 0;
      for (int unsigned k = 1; k <= 5; k++) cyc_exp(8'h01 << k, 3'(k), 1'b1);
      rst = 1; start = 1; clrsc = 1; ldir = 1; bus_in = 8'hEE;
      cyc_exp(8'h00, 3'd0, 1'b0);
      rst = 0; clear_inputs();
      tests++;
      if (ir !== 8'h00 || instr_count !== 16'd0 || D !== 8'h01) begin
         fails++;
         $display("FAIL reset_mid: ir=%h cnt=%0d D=%h, want 00 0 01", ir, instr_count, D);
      end
      start = 1; cyc_exp(8'h01, 3'd0, 1'b1);
      start = 0; cyc_exp(8'h02, 3'd1, 1'b1);
   endtask

   task automatic test_count_wrap;
      do_reset();
      start = 1; tick();
      start = 0; clrsc = 1;
      for (int unsigned k = 0; k < 65535; k++) tick();
      tests++;
      if (instr_count !== 16'hFFFF) begin
         fails++;
         $display("FAIL count_max: got %h want FFFF", instr_count);
      end
      tick();
      clrsc = 0;
      tests++;
      if (instr_count !== 16'h0000) begin
         fails++;
         $display("FAIL count_wrap: got %h want 0000", instr_count);
      end
   endtask

`ifdef SINGLE_STEP_EN
   task automatic test_step;
      do_reset();
      start = 1; cyc_exp(8'h01, 3'd0, 1'b1);
      start = 0; halt_req = 1; clrsc = 1;
      cyc_exp(8'h00, 3'd0, 1'b0);
      halt_req = 0; clrsc = 0;
      step = 1; cyc_exp(8'h01, 3'd0, 1'b1);
      step = 0; cyc_exp(8'h02, 3'd1, 1'b1);
      cyc_exp(8'h04, 3'd2, 1'b1);
      clrsc = 1; cyc_exp(8'h00, 3'd0, 1'b0);
      clrsc = 0; cyc_exp(8'h00, 3'd0, 1'b0);
      tests++;
      if (instr_count !== 16'd2) begin
         fails++;
         $display("FAIL step_count: got %0d want 2", instr_count);
      end
   endtask
`endif

   initial begin
      rst = 1; clear_inputs();
      test_reset();
      test_start();
      test_instr();
      test_halt();
      test_wrap();
      test_reset_mid();
`ifdef SINGLE_STEP_EN
      test_step();
`endif
      test_count_wrap();
      tick(); tick();
      tests++;
      if (q.size() != 0) begin
         fails++;
         $display("FAIL sb_drain: %0d entries left, want 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/timing_decode.md
TIMING_DECODE -- requirements
Module: timing_decode

Interface
REQ-001 Clock/reset SHALL be: one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  one-cycle pulse; leaves IDLE or HALT and enters RUN.
REQ-005 halt_req  input  1  level; request stop at next instruction boundary.
REQ-006 clrsc  input  1  sequence-counter clear from control unit (end of instruction).
REQ-007 ldir  input  1  load IR from bus_in.
REQ-008 bus_in  input  8  common-bus value: [7]=I, [6:4]=opcode, [3:0]=address/B field.
REQ-009 T  output  8  one-hot timing signals T0..T7.
REQ-010 D  output  8  one-hot decode of IR[6:4].
REQ-011 I  output  1  IR[7].
REQ-012 B  output  8  {4'b0000, IR[3:0]}.
REQ-013 ir  output  8  instruction register contents.
REQ-014 sc  output  3  sequence counter value.
REQ-015 running  output  1  high in RUN (and STEP when compiled in).
REQ-016 instr_count  output  16  retired-instruction counter.
REQ-017 sc_wrap_err  output  1  sticky flag: SC wrapped 7->0 without clrsc.

Function
REQ-018 FSM states: IDLE, RUN, HALT (plus STEP per REQ-034); reset state IDLE.
REQ-019 IDLE -> RUN on start; HALT -> RUN on start; all other inputs ignored in IDLE/HALT, except step per REQ-034.
REQ-020 RUN -> HALT when clrsc and halt_req are both high in the same cycle; SC becomes 0 on that edge.
REQ-021 Active state (RUN or STEP): clrsc high -> SC=0 next cycle; else SC=SC+1 mod 8; clrsc has priority.
REQ-022 Inactive state (IDLE or HALT): SC held; T = 8'h00.
REQ-023 Active state: T = 1<<sc, combinational from sc; exactly one bit set.
REQ-024 SC increment from 7 without clrsc: SC wraps to 0 and sc_wrap_err sets; it clears only on rst.
REQ-025 IR loads bus_in on the edge where ldir=1 and the state is active; ldir ignored otherwise; IR holds otherwise.
REQ-026 D, I, B are combinational from IR; they are valid in all states.
REQ-027 instr_count increments by 1 per active-state clrsc; wraps 16'hFFFF -> 0.
REQ-028 start while already active: no effect.
REQ-029 Latency: first T0 appears the cycle after start is sampled; each instruction starts with T0 the cycle after clrsc.

Reset
REQ-030 rst high on an edge SHALL set state=IDLE, sc=0, ir=8'h00, instr_count=0, sc_wrap_err=0; outputs T=8'h00, D=8'h01, I=0, B=8'h00, running=0.
REQ-031 rst SHALL override all other inputs, including mid-instruction.
REQ-032 The first edge after rst deasserts SHALL be processed normally.

Configuration
REQ-033 Macro SINGLE_STEP_EN SHALL gate single-step support.
REQ-034 Defined: add input step (1 bit) and state STEP. HALT -> STEP on step; start has priority over step. STEP acts as RUN. STEP -> HALT on clrsc, SC=0 on that edge, halt_req irrelevant. running=1 in STEP.
REQ-035 Undefined: no step port and no STEP state; behaviour is exactly REQ-018..REQ-029.

Verification
REQ-036 rst, then start pulse -> next cycle T=8'h01, running=1; T=02,04,08 on the following cycles.
REQ-037 ldir=1 with bus_in=8'hA5 at sc=1 -> ir=A5, I=1, D=8'h04, B=8'h05; clrsc at sc=3 -> T=8'h01 next cycle, instr_count=1.
REQ-038 halt_req=1 held, clrsc at sc=4 -> state HALT, sc=0, T=8'h00, running=0; start -> T=8'h01 next cycle.
REQ-039 Run 8 cycles with no clrsc -> sc returns to 0, sc_wrap_err=1; stays 1 until rst.
REQ-040 rst asserted at sc=5 with ir=8'h3C -> next cycle T=8'h00, sc=0, ir=8'h00, instr_count=0, state IDLE.
REQ-041 SINGLE_STEP_EN: in HALT, step pulse -> exactly one instruction runs (T0..clrsc), then HALT, instr_count+1.
